// File: rtl/block_distribution_ctrl_if.sv
// Block distribution bus: upstream block handshake plus distribution-memory write port.
interface block_distribution_ctrl_if #(
  parameter int unsigned LEN_CODED_BLOCK = 66,
  parameter int unsigned N_LANES         = 20
);
  localparam int unsigned AddrW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [LEN_CODED_BLOCK-1:0] i_data;
  logic                       i_valid;
  logic                       o_ready;
  logic [LEN_CODED_BLOCK-1:0] o_data;
  logic [AddrW-1:0]           o_addr;
  logic                       o_enable;
  logic                       o_round_done;
  logic                       o_am_insert;

  // Upstream side: scrambler feeding blocks, observing the memory write port.
  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_data,
    input  o_addr,
    input  o_enable,
    input  o_round_done,
    input  o_am_insert
  );

  // Controller side.
  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_data,
    output o_addr,
    output o_enable,
    output o_round_done,
    output o_am_insert
  );
endinterface

// File: rtl/block_distribution_ctrl.sv
// Round-robin lane writer for the 100GbE PCS TX distribution memory.
// Every AM_PERIOD rounds it stalls upstream for one N_LANES-cycle gap in which the
// alignment-marker stage writes one AM per lane (o_am_insert, lane on o_addr).
module block_distribution_ctrl #(
  parameter int unsigned LEN_CODED_BLOCK = 66,
  parameter int unsigned N_LANES         = 20,
  parameter int unsigned AM_PERIOD       = 16383
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  block_distribution_ctrl_if.slave bus
);
  localparam int unsigned LaneW  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int unsigned RoundW = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam logic [LaneW-1:0]  LaneLast  = LaneW'(N_LANES - 1);
  localparam logic [RoundW-1:0] RoundLast = RoundW'(AM_PERIOD - 1);

  typedef enum logic [0:0] {StRun, StGap} state_e;

  state_e                     state_q, state_d;
  logic [LaneW-1:0]           lane_cnt_q, lane_cnt_d;
  logic [LaneW-1:0]           gap_cnt_q, gap_cnt_d;
  logic [RoundW-1:0]          round_cnt_q, round_cnt_d;
  logic [LEN_CODED_BLOCK-1:0] data_q, data_d;
  logic [LaneW-1:0]           addr_q, addr_d;
  logic                       enable_q, enable_d;
  logic                       round_done_q, round_done_d;
  logic                       am_insert_q, am_insert_d;
  logic                       ready;
  logic                       transfer;

  // Ready depends only on the state register and reset, never on i_valid.
  assign ready    = (state_q == StRun) && i_reset;
  assign transfer = bus.i_valid && ready;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    round_cnt_d  = round_cnt_q;
    data_d       = data_q;
    addr_d       = addr_q;
    enable_d     = 1'b0;
    round_done_d = 1'b0;
    am_insert_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (transfer) begin
          data_d   = bus.i_data;
          addr_d   = lane_cnt_q;
          enable_d = 1'b1;
          if (lane_cnt_q == LaneLast) begin
            lane_cnt_d   = '0;
            round_done_d = 1'b1;
            if (round_cnt_q == RoundLast) begin
              round_cnt_d = '0;
              gap_cnt_d   = '0;
              state_d     = StGap;
            end else begin
              round_cnt_d = round_cnt_q + RoundW'(1);
            end
          end else begin
            lane_cnt_d = lane_cnt_q + LaneW'(1);
          end
        end
      end
      StGap: begin
        // i_valid is ignored here; o_ready is already low.
        am_insert_d = 1'b1;
        addr_d      = gap_cnt_q;
        if (gap_cnt_q == LaneLast) begin
          gap_cnt_d  = '0;
          lane_cnt_d = '0;
          state_d    = StRun;
        end else begin
          gap_cnt_d = gap_cnt_q + LaneW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State and output registers; reset aborts any partial round or gap.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= StRun;
      lane_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      round_cnt_q  <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      enable_q     <= 1'b0;
      round_done_q <= 1'b0;
      am_insert_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      round_cnt_q  <= round_cnt_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      enable_q     <= enable_d;
      round_done_q <= round_done_d;
      am_insert_q  <= am_insert_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_data       = data_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_enable     = enable_q;
  assign bus.o_round_done = round_done_q;
  assign bus.o_am_insert  = am_insert_q;
endmodule

// File: tb/tb_block_distribution_ctrl.sv
// Scoreboard bench: two instances (20 lanes / period 4, and 4 lanes / period 2).
// The driver predicts writes and AM slots from block counts; monitors pop and compare.
module tb_block_distribution_ctrl;
  localparam int unsigned Len = 66;
  localparam int unsigned NA  = 20;
  localparam int unsigned PA  = 4;
  localparam int unsigned NB  = 4;
  localparam int unsigned PB  = 2;

  typedef struct packed {
    logic            am;
    logic            rd;
    logic [4:0]      addr;
    logic [Len-1:0]  data;
    logic [31:0]     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  block_distribution_ctrl_if #(.LEN_CODED_BLOCK(Len), .N_LANES(NA)) bus_a ();
  block_distribution_ctrl_if #(.LEN_CODED_BLOCK(Len), .N_LANES(NB)) bus_b ();

  block_distribution_ctrl #(.LEN_CODED_BLOCK(Len), .N_LANES(NA), .AM_PERIOD(PA)) dut_a (
    .i_clock(clk),
    .i_reset(rst_a),
    .bus    (bus_a)
  );

  block_distribution_ctrl #(.LEN_CODED_BLOCK(Len), .N_LANES(NB), .AM_PERIOD(PB)) dut_b (
    .i_clock(clk),
    .i_reset(rst_b),
    .bus    (bus_b)
  );

  exp_t        exp_q[2][$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned n_acc[2];
  int unsigned gap_left[2];
  int unsigned lanes[2];
  int unsigned period[2];
  bit          held[2];
  logic [Len-1:0] hdata[2];
  int unsigned kseq = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int idx, input logic [Len-1:0] got,
                       input logic [Len-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%0h want=%0h", name, idx, cyc, got, want);
    end
  endtask

  task automatic fail_now(input string name, input int idx);
    checks++;
    failures++;
    $display("FAIL %s dut=%0d cyc=%0d got=output want=none_or_other", name, idx, cyc);
  endtask

  // Monitor: compare each observed write / AM slot against the queue front.
  task automatic mon(input int idx, input logic en, input logic am, input logic rd,
                     input logic [4:0] addr, input logic [Len-1:0] data);
    exp_t e;
    check("excl_en_am", idx, Len'(en && am), '0);
    check("rd_without_en", idx, Len'(rd && !en), '0);
    if (en || am) begin
      if (exp_q[idx].size() == 0) begin
        fail_now("unexpected_out", idx);
      end else begin
        e = exp_q[idx].pop_front();
        check("kind_am", idx, Len'(am), Len'(e.am));
        check("due_cycle", idx, Len'(cyc), Len'(e.due));
        check("addr", idx, Len'(addr), Len'(e.addr));
        check("round_done", idx, Len'(rd), Len'(e.rd));
        if (!e.am) check("data", idx, data, e.data);
      end
    end else if (exp_q[idx].size() != 0 && exp_q[idx][0].due == cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_out dut=%0d cyc=%0d got=none want=addr %0d", idx, cyc,
               exp_q[idx][0].addr);
    end
  endtask

  always @(negedge clk) begin
    if (rst_a) mon(0, bus_a.o_enable, bus_a.o_am_insert, bus_a.o_round_done,
                   5'(bus_a.o_addr), bus_a.o_data);
    if (rst_b) mon(1, bus_b.o_enable, bus_b.o_am_insert, bus_b.o_round_done,
                   5'(bus_b.o_addr), bus_b.o_data);
  end

  // Reference model step: one cycle of upstream behaviour for instance idx.
  task automatic step(input int idx, input int unsigned pct, input bit seq);
    exp_t e;
    bit   rdy_m;
    logic rdy;
    rdy_m = (gap_left[idx] == 0);
    rdy   = (idx == 0) ? bus_a.o_ready : bus_b.o_ready;
    check("ready", idx, Len'(rdy), Len'(rdy_m));
    if (!held[idx] && $urandom_range(99) < pct) begin
      held[idx] = 1'b1;
      if (seq) begin
        hdata[idx] = Len'(kseq);
        kseq++;
      end else begin
        hdata[idx] = {2'($urandom), $urandom, $urandom};
      end
    end
    if (idx == 0) begin
      bus_a.i_valid = held[idx];
      bus_a.i_data  = hdata[idx];
    end else begin
      bus_b.i_valid = held[idx];
      bus_b.i_data  = hdata[idx];
    end
    if (gap_left[idx] > 0) gap_left[idx]--;
    if (held[idx] && rdy_m) begin
      e.am   = 1'b0;
      e.rd   = ((n_acc[idx] % lanes[idx]) == lanes[idx] - 1);
      e.addr = 5'(n_acc[idx] % lanes[idx]);
      e.data = hdata[idx];
      e.due  = cyc + 1;
      exp_q[idx].push_back(e);
      n_acc[idx]++;
      held[idx] = 1'b0;
      if ((n_acc[idx] % (lanes[idx] * period[idx])) == 0) begin
        gap_left[idx] = lanes[idx];
        for (int a = 0; a < int'(lanes[idx]); a++) begin
          e.am   = 1'b1;
          e.rd   = 1'b0;
          e.addr = 5'(a);
          e.data = '0;
          e.due  = cyc + 2 + 32'(a);
          exp_q[idx].push_back(e);
        end
      end
    end
  endtask

  task automatic tick(input int unsigned pa, input int unsigned pb, input bit seq);
    @(posedge clk);
    #1;
    if (rst_a) step(0, pa, seq);
    if (rst_b) step(1, pb, 1'b0);
  endtask

  task automatic model_clear(input int idx);
    exp_q[idx].delete();
    n_acc[idx]    = 0;
    gap_left[idx] = 0;
    held[idx]     = 1'b0;
  endtask

  task automatic check_a_idle(input string tag, input logic want_ready);
    check({tag, "_ready"}, 0, Len'(bus_a.o_ready), Len'(want_ready));
    check({tag, "_enable"}, 0, Len'(bus_a.o_enable), '0);
    check({tag, "_am"}, 0, Len'(bus_a.o_am_insert), '0);
    check({tag, "_rd"}, 0, Len'(bus_a.o_round_done), '0);
    check({tag, "_addr"}, 0, Len'(bus_a.o_addr), '0);
    check({tag, "_data"}, 0, bus_a.o_data, '0);
  endtask

  // Asserted right after a tick; instance B keeps running meanwhile.
  task automatic reset_a();
    rst_a = 1'b0;
    bus_a.i_valid = 1'b0;
    model_clear(0);
    #1;
    check_a_idle("rst_async", 1'b0);
    tick(0, 70, 1'b0);
    tick(0, 70, 1'b0);
    rst_a = 1'b1;
  endtask

  initial begin
    lanes[0] = NA; period[0] = PA;
    lanes[1] = NB; period[1] = PB;
    model_clear(0);
    model_clear(1);
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.i_valid = 1'b0;
    bus_a.i_data  = '0;
    bus_b.i_valid = 1'b0;
    bus_b.i_data  = '0;
    #2;
    check_a_idle("in_reset", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Idle after release: outputs stay zero, ready high.
    repeat (3) tick(0, 0, 1'b0);
    check_a_idle("idle", 1'b1);

    // Reset in mid-round; next block must land on lane 0.
    repeat (27) tick(100, 70, 1'b0);
    reset_a();

    // 40 back-to-back blocks with data = k.
    kseq = 0;
    for (int i = 0; i < 200 && n_acc[0] < 40; i++) tick(100, 70, 1'b1);
    check("b2b_count", 0, Len'(n_acc[0]), Len'(40));

    // Random bubbles over several rounds (crosses the first gap).
    repeat (150) tick(50, 70, 1'b0);

    // Continuous valid through another gap; held block waits for lane 0.
    repeat (120) tick(100, 70, 1'b0);

    // Reset inside a gap at AM lane 7.
    for (int i = 0; i < 400 && gap_left[0] != 11; i++) tick(100, 70, 1'b0);
    check("gap_reached", 0, Len'(gap_left[0]), Len'(11));
    check("gap_am", 0, Len'(bus_a.o_am_insert), Len'(1));
    check("gap_addr", 0, Len'(bus_a.o_addr), Len'(NA - 11 - 2));
    reset_a();
    repeat (200) tick(100, 70, 1'b0);

    // Drain.
    repeat (30) tick(0, 0, 1'b0);
    check("drain_a", 0, Len'(exp_q[0].size()), '0);
    check("drain_b", 1, Len'(exp_q[1].size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/block_distribution_ctrl.md
Name: block_distribution_ctrl

Overview:
- Upstream controller for the per-lane block distribution memory in the 100GbE PCS TX path.
- Accepts the serial stream of 66-bit scrambled blocks and produces the write data, lane address and write enable that drive the distribution memory.
- Addresses lanes in round-robin order and counts distribution rounds.
- Every AM_PERIOD rounds it opens a one-round gap: upstream is stalled and the alignment-marker stage writes one AM per lane.

Parameters:
- LEN_CODED_BLOCK, 66, width of one coded block.
- N_LANES, 20, number of PCS lanes; also the length of the AM gap in cycles.
- AM_PERIOD, 16383, data rounds between AM gaps (minimum 2).

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_data  in  LEN_CODED_BLOCK  coded block from the scrambler.
- i_valid  in  1  i_data valid this cycle.
- o_ready  out  1  block accepted when i_valid=1 and o_ready=1.
- o_data  out  LEN_CODED_BLOCK  registered block to the memory write port.
- o_addr  out  $clog2(N_LANES)  lane address; in GAP it carries the AM lane index.
- o_enable  out  1  memory write strobe for o_data/o_addr.
- o_round_done  out  1  one-cycle pulse with the write to lane N_LANES-1.
- o_am_insert  out  1  high for the N_LANES gap cycles; o_addr gives the AM lane.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=RUN; lane_cnt=0, round_cnt=0, gap_cnt=0.
  - o_data=0, o_addr=0, o_enable=0, o_round_done=0, o_am_insert=0.
  - o_ready=0 while reset is asserted.
  - Asserting reset mid-round or mid-gap aborts immediately. Partially written rounds are discarded; the first block after release goes to lane 0.
- o_ready = (state==RUN) and reset deasserted. It is combinational from the state register only and never depends on i_valid.
- Handshake:
  - A transfer occurs when i_valid=1 and o_ready=1.
  - When i_valid=1 and o_ready=0, the block is not captured and no state changes. Upstream must hold the block.
- RUN, transfer in cycle t. On the t+1 edge (one-cycle latency):
  - o_data=i_data, o_addr=lane_cnt, o_enable=1.
  - lane_cnt advances by 1 and wraps from N_LANES-1 to 0.
- RUN, no transfer: o_enable=0 next cycle. o_data and o_addr hold; all counters hold. Bubbles are permitted at any lane position.
- Round completion (transfer with lane_cnt=N_LANES-1):
  - o_round_done=1 in the same cycle as that write's o_enable.
  - If round_cnt<AM_PERIOD-1: round_cnt increments.
  - Else: round_cnt=0, state goes to GAP, gap_cnt=0. o_ready drops on the cycle following the last accepted block.
- GAP:
  - o_ready=0, o_enable=0, o_am_insert=1, o_addr=gap_cnt (driven registered).
  - gap_cnt counts 0..N_LANES-1, so o_am_insert is high for exactly N_LANES cycles.
  - After gap_cnt=N_LANES-1: state returns to RUN, o_am_insert=0, lane_cnt=0.
  - i_valid is ignored throughout GAP.
- o_round_done is never asserted in GAP. o_enable and o_am_insert are mutually exclusive.
- Counter widths:
  - lane_cnt and gap_cnt: $clog2(N_LANES) bits.
  - round_cnt: $clog2(AM_PERIOD) bits.
  - Comparisons are equality against constants; no arithmetic overflow is possible.
- Throughput: one block per cycle in RUN with no internal stalls. The only deliberate stall is the N_LANES-cycle GAP per AM_PERIOD rounds.

Test Plan:
1. Reset release, i_valid=0 -> all outputs 0; o_ready=1 from the first edge after release. Assert reset during a round -> outputs clear immediately; next block goes to lane 0.
2. 40 back-to-back blocks with i_data=k (k=0..39) -> o_enable high 40 cycles starting one cycle after the first transfer; o_addr = k mod 20; o_data=k. o_round_done pulses on k=19 and k=39.
3. Random i_valid bubbles (50%) over 3 rounds -> every accepted block appears exactly once, in order; addresses stay 0..19 round-robin; no writes during bubbles.
4. AM_PERIOD=4, continuous valid:
   - After the 4th round (block 79), o_ready=0 for 20 cycles; o_am_insert=1 with o_addr 0..19; o_enable=0.
   - A held i_valid block is not consumed in the gap and is written to lane 0 after the gap.
5. AM_PERIOD=4, assert reset at gap cycle 7 -> o_am_insert drops immediately; after release state=RUN, round_cnt=0; the next gap occurs after another 80 blocks.
6. N_LANES=4, AM_PERIOD=2 (parameter sweep) -> o_addr wraps 3->0; gap lasts 4 cycles after every 8 blocks.
